// File: rtl/qdma_desc_arb_pkg.sv
// Shared types and default constants for the QDMA descriptor arbiter.
package qdma_desc_arb_pkg;

    localparam int unsigned DefNumReq  = 4;
    localparam int unsigned DefDescW   = 128;
    localparam int unsigned DefCreditW = 8;

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } arb_state_e;

    function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/qdma_desc_rr_pick.sv
// Round-robin picker: first eligible requester at or after ptr_i, wrapping modulo NumReq.
module qdma_desc_rr_pick #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] elig_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] grant_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              any_o
);

    logic [IdxW-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand = IdxW'((32'(ptr_i) + k) % NumReq);
            if (!any_o && elig_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/qdma_desc_arbiter.sv
// Credit-gated round-robin merge of descriptor requesters onto one QDMA bypass port.
// Optional per-requester grant statistics are built when QDMA_DESC_ARB_STATS_EN is defined.
module qdma_desc_arbiter
    import qdma_desc_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = DefNumReq,
    parameter int unsigned DESC_W   = DefDescW,
    parameter int unsigned CREDIT_W = DefCreditW
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DESC_W-1:0]  req_desc,
    input  logic [NUM_REQ-1:0]         cfg_enable,
    input  logic [CREDIT_W-1:0]        cfg_credit_init,
    input  logic                       cfg_load,
    input  logic [NUM_REQ-1:0]         credit_ret,
    output logic                       m_desc_valid,
    input  logic                       m_desc_ready,
    output logic [DESC_W-1:0]          m_desc,
    output logic [$clog2(NUM_REQ)-1:0] m_desc_src
`ifdef QDMA_DESC_ARB_STATS_EN
    ,
    input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
    output logic [31:0]                stat_grants
`endif
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam logic [CREDIT_W-1:0] CreditMax = '1;

    arb_state_e          state_q;
    logic [IdxW-1:0]     ptr_q;
    logic [IdxW-1:0]     src_q;
    logic [DESC_W-1:0]   desc_q;
    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [NUM_REQ-1:0]  grant;
    logic [IdxW-1:0]     pick_idx;
    logic                pick_any;
    logic                accept;

    qdma_desc_rr_pick #(
        .NumReq (NUM_REQ),
        .IdxW   (IdxW)
    ) u_pick (
        .elig_i  (elig),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Reset masks the grant so no requester sees a handshake that is then discarded.
    assign accept    = !ARESET && pick_any && ((state_q == StEmpty) || m_desc_ready);
    assign grant     = accept ? pick_grant : '0;
    assign req_ready = grant;

    assign m_desc_valid = (state_q == StFull);
    assign m_desc       = desc_q;
    assign m_desc_src   = src_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= StEmpty;
            ptr_q   <= '0;
            desc_q  <= '0;
            src_q   <= '0;
        end else if (accept) begin
            state_q <= StFull;
            desc_q  <= req_desc[32'(pick_idx)*DESC_W +: DESC_W];
            src_q   <= pick_idx;
            ptr_q   <= IdxW'(wrap_inc(32'(pick_idx), NUM_REQ));
        end else if ((state_q == StFull) && m_desc_ready) begin
            state_q <= StEmpty;
        end
    end

`ifdef QDMA_DESC_ARB_STATS_EN
    logic [31:0] grant_cnt [NUM_REQ];
    logic [31:0] stat_q;
`endif

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        logic [CREDIT_W-1:0] credit_q;

        assign elig[gi] = req_valid[gi] && cfg_enable[gi] && (credit_q != '0);

        // Return and grant in the same cycle cancel; a return at the ceiling is dropped.
        always_ff @(posedge ACLK) begin
            if (ARESET || cfg_load) begin
                credit_q <= cfg_credit_init;
            end else if (credit_ret[gi] && !grant[gi] && (credit_q != CreditMax)) begin
                credit_q <= credit_q + CREDIT_W'(1);
            end else if (grant[gi] && !credit_ret[gi]) begin
                credit_q <= credit_q - CREDIT_W'(1);
            end
        end

`ifdef QDMA_DESC_ARB_STATS_EN
        logic [31:0] cnt_q;

        always_ff @(posedge ACLK) begin
            if (ARESET) begin
                cnt_q <= '0;
            end else if (grant[gi]) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end

        assign grant_cnt[gi] = cnt_q;
`endif
    end

`ifdef QDMA_DESC_ARB_STATS_EN
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            stat_q <= '0;
        end else begin
            stat_q <= (32'(stat_sel) < NUM_REQ) ? grant_cnt[stat_sel] : '0;
        end
    end

    assign stat_grants = stat_q;
`endif

endmodule

// File: tb/tb_qdma_desc_arbiter.sv
// Self-checking bench for qdma_desc_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the arbitration and credit rules.
module tb_qdma_desc_arbiter;

    localparam int N    = 4;
    localparam int DW   = 128;
    localparam int CW   = 8;
    localparam int IW   = 2;
    localparam int CMAX = 255;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_desc;
    logic [N-1:0]      cfg_enable;
    logic [CW-1:0]     cfg_credit_init;
    logic              cfg_load;
    logic [N-1:0]      credit_ret;
    logic              m_desc_valid;
    logic              m_desc_ready;
    logic [DW-1:0]     m_desc;
    logic [IW-1:0]     m_desc_src;
`ifdef QDMA_DESC_ARB_STATS_EN
    logic [IW-1:0]     stat_sel;
    logic [31:0]       stat_grants;
    logic [31:0]       mstat;
`endif

    qdma_desc_arbiter #(
        .NUM_REQ  (N),
        .DESC_W   (DW),
        .CREDIT_W (CW)
    ) dut (
        .ACLK            (ACLK),
        .ARESET          (ARESET),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_desc        (req_desc),
        .cfg_enable      (cfg_enable),
        .cfg_credit_init (cfg_credit_init),
        .cfg_load        (cfg_load),
        .credit_ret      (credit_ret),
        .m_desc_valid    (m_desc_valid),
        .m_desc_ready    (m_desc_ready),
        .m_desc          (m_desc),
        .m_desc_src      (m_desc_src)
`ifdef QDMA_DESC_ARB_STATS_EN
        ,
        .stat_sel        (stat_sel),
        .stat_grants     (stat_grants)
`endif
    );

    always #5 ACLK = ~ACLK;

    // Behavioural model state
    int           mc [N];
    int           mgrants [N];
    int           mptr;
    bit           mfull;
    logic [DW-1:0] mdesc;
    int           msrc;
    bit           eacc;
    int           ewin;
    logic [N-1:0] eready;

    int vectors = 0;
    int errors  = 0;

    task automatic model_eval();
        eacc   = 1'b0;
        ewin   = 0;
        eready = '0;
        if (!ARESET && (!mfull || m_desc_ready)) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (mptr + k) % N;
                if (!eacc && req_valid[j] && cfg_enable[j] && mc[j] != 0) begin
                    eacc = 1'b1;
                    ewin = j;
                end
            end
        end
        if (eacc) eready[ewin] = 1'b1;
    endtask

    // Advance one clock; the model consumes the inputs that were stable at the edge.
    task automatic tick();
        model_eval();
        @(posedge ACLK);
`ifdef QDMA_DESC_ARB_STATS_EN
        mstat = ARESET ? 32'd0 : 32'(mgrants[stat_sel]);
`endif
        if (ARESET) begin
            mfull = 1'b0;
            mptr  = 0;
            mdesc = '0;
            msrc  = 0;
            for (int i = 0; i < N; i++) begin
                mc[i]      = int'(cfg_credit_init);
                mgrants[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = mc[i] + int'(credit_ret[i]) - ((eacc && ewin == i) ? 1 : 0);
                mc[i] = cfg_load ? int'(cfg_credit_init) : ((c > CMAX) ? CMAX : c);
            end
            if (eacc) begin
                mfull = 1'b1;
                mdesc = req_desc[ewin*DW +: DW];
                msrc  = ewin;
                mptr  = (ewin + 1) % N;
                mgrants[ewin]++;
            end else if (mfull && m_desc_ready) begin
                mfull = 1'b0;
            end
        end
        #1;
    endtask

    task automatic rand_descs();
        for (int i = 0; i < N; i++) begin
            req_desc[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic test_reset();
        ARESET          = 1'b1;
        req_valid       = '1;
        cfg_enable      = '1;
        cfg_credit_init = 8'd8;
        m_desc_ready    = 1'b1;
        rand_descs();
        tick();
        tick();
        vectors++;
        if (m_desc_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", m_desc_valid);
        end
        vectors++;
        if (m_desc !== '0) begin
            errors++;
            $display("FAIL reset_desc: got %h want 0", m_desc);
        end
        vectors++;
        if (m_desc_src !== '0) begin
            errors++;
            $display("FAIL reset_src: got %0d want 0", m_desc_src);
        end
        vectors++;
        if (req_ready !== '0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
    endtask

    task automatic test_round_robin();
        int           order [5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] want;
        ARESET = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            want           = '0;
            want[order[c]] = 1'b1;
            vectors++;
            if (req_ready !== want) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got %b want %b", c, req_ready, want);
            end
            tick();
            vectors++;
            if (m_desc_valid !== 1'b1 || m_desc_src !== IW'(order[c]) ||
                m_desc !== req_desc[order[c]*DW +: DW]) begin
                errors++;
                $display("FAIL rr_out[%0d]: got v=%b src=%0d want v=1 src=%0d",
                         c, m_desc_valid, m_desc_src, order[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        req_valid = '0;
        tick();
        vectors++;
        if (m_desc_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got %b want 0", m_desc_valid);
        end
        req_valid            = 4'b0010;
        req_desc[DW +: DW]   = 128'hA5;
        m_desc_ready         = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_first_grant: got %b want 0010", req_ready);
        end
        tick();
        req_desc[DW +: DW] = 128'h5A;
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready);
            end
            tick();
            vectors++;
            if (m_desc !== 128'hA5 || m_desc_valid !== 1'b1 || m_desc_src !== 2'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got desc=%h v=%b want desc=a5 v=1",
                         c, m_desc, m_desc_valid);
            end
        end
        m_desc_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release: got %b want 0010", req_ready);
        end
        tick();
        vectors++;
        if (m_desc !== 128'h5A) begin
            errors++;
            $display("FAIL bp_next_desc: got %h want 5a", m_desc);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_credit_limit();
        int g;
        cfg_credit_init = 8'd2;
        cfg_load        = 1'b1;
        tick();
        cfg_load  = 1'b0;
        req_valid = 4'b0010;
        g = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            model_eval();
            vectors++;
            if (req_ready !== eready) begin
                errors++;
                $display("FAIL cl_ready[%0d]: got %b want %b", c, req_ready, eready);
            end
            if (req_ready[1]) g++;
            tick();
        end
        vectors++;
        if (g !== 2) begin
            errors++;
            $display("FAIL cl_grants: got %0d want 2", g);
        end
        credit_ret = 4'b0010;
        tick();
        credit_ret = '0;
        g = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (req_ready[1]) g++;
            tick();
        end
        vectors++;
        if (g !== 1) begin
            errors++;
            $display("FAIL cl_after_ret: got %0d want 1", g);
        end
    endtask

    task automatic test_credit_saturate();
        int g;
        req_valid       = '0;
        cfg_credit_init = 8'd3;
        cfg_load        = 1'b1;
        tick();
        cfg_load   = 1'b0;
        req_valid  = 4'b0001;
        credit_ret = 4'b0001;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL cs_same_cycle: got %b want 0001", req_ready);
        end
        tick();
        credit_ret = '0;
        g = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (req_ready[0]) g++;
            tick();
        end
        vectors++;
        if (g !== 3) begin
            errors++;
            $display("FAIL cs_cancel: got %0d grants want 3", g);
        end
        req_valid       = '0;
        cfg_credit_init = 8'd255;
        cfg_load        = 1'b1;
        tick();
        cfg_load   = 1'b0;
        credit_ret = 4'b0001;
        tick();
        credit_ret = '0;
        req_valid  = 4'b0001;
        g = 0;
        for (int c = 0; c < 260; c++) begin
            #1;
            if (req_ready[0]) g++;
            tick();
        end
        vectors++;
        if (g !== 255) begin
            errors++;
            $display("FAIL cs_saturate: got %0d grants want 255", g);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        cfg_credit_init = 8'd8;
        cfg_load        = 1'b1;
        tick();
        cfg_load     = 1'b0;
        req_valid    = '1;
        m_desc_ready = 1'b1;
        tick();
        tick();
        m_desc_ready = 1'b0;
        tick();
        vectors++;
        if (m_desc_valid !== 1'b1) begin
            errors++;
            $display("FAIL rm_full: got %b want 1", m_desc_valid);
        end
        ARESET = 1'b1;
        #1;
        vectors++;
        if (req_ready !== '0) begin
            errors++;
            $display("FAIL rm_ready_in_reset: got %b want 0000", req_ready);
        end
        tick();
        vectors++;
        if (m_desc_valid !== 1'b0 || m_desc !== '0) begin
            errors++;
            $display("FAIL rm_cleared: got v=%b desc=%h want v=0 desc=0", m_desc_valid, m_desc);
        end
        ARESET       = 1'b0;
        m_desc_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rm_first_grant: got %b want 0001", req_ready);
        end
        tick();
        vectors++;
        if (m_desc_src !== 2'd0) begin
            errors++;
            $display("FAIL rm_first_src: got %0d want 0", m_desc_src);
        end
        req_valid = '0;
        tick();
    endtask

`ifdef QDMA_DESC_ARB_STATS_EN
    task automatic test_stats();
        cfg_credit_init = 8'd20;
        cfg_load        = 1'b1;
        tick();
        cfg_load  = 1'b0;
        stat_sel  = 2'd2;
        req_valid = 4'b0100;
        for (int c = 0; c < 10; c++) tick();
        req_valid = '0;
        tick();
        tick();
        vectors++;
        if (stat_grants !== 32'd10) begin
            errors++;
            $display("FAIL stats_count: got %0d want 10", stat_grants);
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            ARESET          = ($urandom_range(0, 99) == 0);
            cfg_load        = ($urandom_range(0, 49) == 0);
            cfg_credit_init = CW'($urandom_range(0, 6));
            req_valid       = N'($urandom);
            cfg_enable      = N'($urandom | $urandom);
            credit_ret      = N'($urandom & $urandom);
            m_desc_ready    = ($urandom_range(0, 3) != 0);
`ifdef QDMA_DESC_ARB_STATS_EN
            stat_sel        = IW'($urandom);
`endif
            rand_descs();
            #1;
            model_eval();
            vectors++;
            if (req_ready !== eready) begin
                errors++;
                $display("FAIL rnd_ready[%0d]: got %b want %b", c, req_ready, eready);
            end
            tick();
            vectors++;
            if (m_desc_valid !== mfull || m_desc !== mdesc || m_desc_src !== IW'(msrc)) begin
                errors++;
                $display("FAIL rnd_out[%0d]: got v=%b src=%0d desc=%h want v=%b src=%0d desc=%h",
                         c, m_desc_valid, m_desc_src, m_desc, mfull, msrc, mdesc);
            end
`ifdef QDMA_DESC_ARB_STATS_EN
            vectors++;
            if (stat_grants !== mstat) begin
                errors++;
                $display("FAIL rnd_stat[%0d]: got %0d want %0d", c, stat_grants, mstat);
            end
`endif
        end
    endtask

    initial begin
        ARESET          = 1'b1;
        req_valid       = '0;
        req_desc        = '0;
        cfg_enable      = '0;
        cfg_credit_init = '0;
        cfg_load        = 1'b0;
        credit_ret      = '0;
        m_desc_ready    = 1'b0;
`ifdef QDMA_DESC_ARB_STATS_EN
        stat_sel        = '0;
`endif
        mfull = 1'b0;
        mptr  = 0;
        mdesc = '0;
        msrc  = 0;
        for (int i = 0; i < N; i++) begin
            mc[i]      = 0;
            mgrants[i] = 0;
        end
        @(negedge ACLK);

        test_reset();
        test_round_robin();
        test_backpressure();
        test_credit_limit();
        test_credit_saturate();
        test_reset_mid();
`ifdef QDMA_DESC_ARB_STATS_EN
        test_stats();
`endif
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
